// File: rtl/mmx_count_checker.sv
// mmx_count_checker
//   Receive-side checker for a free-running WIDTH-bit up-counter stream.
//   Each valid sample is compared against the previous sample plus one,
//   modulo 2^WIDTH. After LOCK_N consecutive good increments the checker
//   locks. While locked it reports mismatches and counter wraps. After
//   UNLOCK_N consecutive mismatches it drops back to acquisition.
//
// Ports
//   clk        in   1      clock, all logic on posedge
//   reset      in   1      synchronous, active-high
//   in_valid   in   1      in_count carries a new sample this cycle
//   in_count   in   WIDTH  sampled counter value
//   locked     out  1      high while in the LOCKED state
//   err_pulse  out  1      one-cycle pulse: mismatch seen while locked
//   wrap_pulse out  1      one-cycle pulse: good 2^WIDTH-1 -> 0 step while locked
//   err_count  out  ERR_W  locked mismatches, saturating at 2^ERR_W-1
module mmx_count_checker #(
    parameter int WIDTH    = 7,
    parameter int ERR_W    = 8,
    parameter int LOCK_N   = 4,
    parameter int UNLOCK_N = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_count,
    output logic             locked,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int GR_W = $clog2(LOCK_N + 1);
    localparam int BR_W = $clog2(UNLOCK_N + 1);

    localparam logic [GR_W-1:0]  LOCK_TH   = GR_W'(LOCK_N);
    localparam logic [BR_W-1:0]  UNLOCK_TH = BR_W'(UNLOCK_N);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [GR_W-1:0]  good_run;
    logic [BR_W-1:0]  bad_run;

    logic [WIDTH-1:0] expected;
    logic             match;
    logic [GR_W-1:0]  good_inc;
    logic [BR_W-1:0]  bad_inc;

    // Saturating increments: run counters stop at their thresholds, the
    // error counter stops at all-ones.
    function automatic logic [GR_W-1:0] sat_inc_good(input logic [GR_W-1:0] v);
        return (v >= LOCK_TH) ? LOCK_TH : v + {{(GR_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [BR_W-1:0] sat_inc_bad(input logic [BR_W-1:0] v);
        return (v >= UNLOCK_TH) ? UNLOCK_TH : v + {{(BR_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + {{(ERR_W-1){1'b0}}, 1'b1};
    endfunction

    // Natural truncation gives the 2^WIDTH-1 -> 0 wrap.
    assign expected = prev + {{(WIDTH-1){1'b0}}, 1'b1};
    assign match    = (in_count == expected);
    assign good_inc = sat_inc_good(good_run);
    assign bad_inc  = sat_inc_bad(bad_run);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            prev       <= '0;
            good_run   <= '0;
            bad_run    <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            err_count  <= '0;
        end else begin
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            if (in_valid) begin
                // Always resync to the newest value, good or bad.
                prev <= in_count;
                case (state)
                    S_IDLE: begin
                        // First sample only seeds prev; nothing to compare yet.
                        state    <= S_ACQUIRE;
                        good_run <= '0;
                    end
                    S_ACQUIRE: begin
                        if (match) begin
                            good_run <= good_inc;
                            if (good_inc == LOCK_TH) begin
                                state   <= S_LOCKED;
                                locked  <= 1'b1;
                                bad_run <= '0;
                            end
                        end else begin
                            good_run <= '0;
                        end
                    end
                    S_LOCKED: begin
                        if (match) begin
                            bad_run    <= '0;
                            wrap_pulse <= (in_count == '0);
                        end else begin
                            // The unlocking mismatch is still reported and counted.
                            err_pulse <= 1'b1;
                            err_count <= sat_inc_err(err_count);
                            bad_run   <= bad_inc;
                            if (bad_inc == UNLOCK_TH) begin
                                state    <= S_ACQUIRE;
                                locked   <= 1'b0;
                                good_run <= '0;
                            end
                        end
                    end
                    default: begin
                        state  <= S_IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mmx_count_checker.sv
module tb_mmx_count_checker;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [6:0] in_count;
    logic       locked;
    logic       err_pulse;
    logic       wrap_pulse;
    logic [7:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;

    mmx_count_checker #(
        .WIDTH(7), .ERR_W(8), .LOCK_N(4), .UNLOCK_N(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_count  (in_count),
        .locked    (locked),
        .err_pulse (err_pulse),
        .wrap_pulse(wrap_pulse),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One valid sample; returns 1 time unit after the capturing edge so the
    // registered outputs for this sample are visible.
    task automatic send(input logic [6:0] v);
        in_valid = 1'b1;
        in_count = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        in_count = 7'd0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b want 0", locked); end
        n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err_pulse got %b want 0", err_pulse); end
        n_tests++; if (wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_wrap_pulse got %b want 0", wrap_pulse); end
        n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count got %0d want 0", err_count); end
        reset = 1'b0;
    endtask

    // Reset, then 0..4: sample 0 seeds, 1..4 are the four good increments.
    task automatic test_lock();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(7'(i));
            n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early[%0d] got %b want 0", i, locked); end
        end
        send(7'd4);
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_after_4 got %b want 1", locked); end
        n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL lock_err_count got %0d want 0", err_count); end
    endtask

    // Continues from test_lock (prev=4): run up to 9, then 10,11,13,14.
    task automatic test_single_error();
        for (int i = 5; i <= 11; i++) begin
            send(7'(i));
            n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL single_pre_pulse[%0d] got %b want 0", i, err_pulse); end
        end
        send(7'd13);
        n_tests++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL single_pulse_13 got %b want 1", err_pulse); end
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL single_locked_13 got %b want 1", locked); end
        send(7'd14);
        n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL single_pulse_14 got %b want 0", err_pulse); end
        n_tests++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL single_err_count got %0d want 1", err_count); end
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL single_locked_14 got %b want 1", locked); end
    endtask

    // Lock on 15..19; 20 good, 25 and 30 bad -> unlock after 30 with 2 errors.
    // Relock needs four good increments: 31,32,33,34.
    task automatic test_unlock_relock();
        do_reset();
        for (int i = 15; i <= 19; i++) send(7'(i));
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL unlock_pre_locked got %b want 1", locked); end
        send(7'd20);
        n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL unlock_pulse_20 got %b want 0", err_pulse); end
        send(7'd25);
        n_tests++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL unlock_pulse_25 got %b want 1", err_pulse); end
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL unlock_locked_25 got %b want 1", locked); end
        send(7'd30);
        n_tests++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL unlock_pulse_30 got %b want 1", err_pulse); end
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL unlock_locked_30 got %b want 0", locked); end
        n_tests++; if (err_count !== 8'd2) begin n_fail++; $display("FAIL unlock_err_count got %0d want 2", err_count); end
        for (int i = 31; i <= 33; i++) begin
            send(7'(i));
            n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL relock_early[%0d] got %b want 0", i, locked); end
        end
        send(7'd34);
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL relock_34 got %b want 1", locked); end
        send(7'd35);
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL relock_35 got %b want 1", locked); end
        n_tests++; if (err_count !== 8'd2) begin n_fail++; $display("FAIL relock_err_count got %0d want 2", err_count); end
    endtask

    task automatic test_wrap();
        logic [6:0] seq [4];
        logic       exp_wrap [4];
        seq = '{7'd126, 7'd127, 7'd0, 7'd1};
        exp_wrap = '{1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 121; i <= 125; i++) send(7'(i));
        for (int i = 0; i < 4; i++) begin
            send(seq[i]);
            n_tests++; if (wrap_pulse !== exp_wrap[i]) begin n_fail++; $display("FAIL wrap_pulse[%0d] got %b want %b", seq[i], wrap_pulse, exp_wrap[i]); end
        end
        idle_cycle();
        n_tests++; if (wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL wrap_idle got %b want 0", wrap_pulse); end
        n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL wrap_err_count got %0d want 0", err_count); end
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL wrap_locked got %b want 1", locked); end
    endtask

    // Wrap while acquiring, repeated value while locked, idle cycles, and a
    // mismatch while acquiring that restarts the good run without counting.
    task automatic test_acquire_cases();
        do_reset();
        send(7'd125); send(7'd126); send(7'd127); send(7'd0);
        n_tests++; if (wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL acq_wrap got %b want 0", wrap_pulse); end
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL acq_wrap_locked got %b want 0", locked); end
        send(7'd1);
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL acq_wrap_lock got %b want 1", locked); end
        send(7'd1);
        n_tests++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL repeat_pulse got %b want 1", err_pulse); end
        n_tests++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL repeat_count got %0d want 1", err_count); end
        idle_cycle();
        n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL idle_pulse got %b want 0", err_pulse); end
        n_tests++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL idle_count got %0d want 1", err_count); end
        send(7'd2);
        n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL repeat_resume got %b want 0", err_pulse); end
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL repeat_locked got %b want 1", locked); end

        do_reset();
        send(7'd0); send(7'd1); send(7'd2); send(7'd7);
        n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL acq_mis_pulse got %b want 0", err_pulse); end
        n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL acq_mis_count got %0d want 0", err_count); end
        send(7'd8); send(7'd9); send(7'd10);
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL acq_mis_early got %b want 0", locked); end
        send(7'd11);
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL acq_mis_lock got %b want 1", locked); end
    endtask

    // 300 isolated mismatches, each followed by a good step so lock holds.
    task automatic test_saturation();
        logic [6:0] v;
        do_reset();
        for (int i = 0; i <= 4; i++) send(7'(i));
        v = 7'd4;
        for (int i = 0; i < 300; i++) begin
            v = v + 7'd2;
            send(v);
            if (i == 253) begin
                n_tests++; if (err_count !== 8'd254) begin n_fail++; $display("FAIL sat_254 got %0d want 254", err_count); end
            end
            if (i == 299) begin
                n_tests++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL sat_pulse_at_max got %b want 1", err_pulse); end
            end
            v = v + 7'd1;
            send(v);
        end
        n_tests++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL sat_hold got %0d want 255", err_count); end
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL sat_locked got %b want 1", locked); end
    endtask

    task automatic test_reset_midrun();
        logic [6:0] v;
        do_reset();
        for (int i = 0; i <= 4; i++) send(7'(i));
        v = 7'd4;
        for (int i = 0; i < 3; i++) begin
            v = v + 7'd2; send(v);
            v = v + 7'd1; send(v);
        end
        n_tests++; if (err_count !== 8'd3) begin n_fail++; $display("FAIL mid_pre_count got %0d want 3", err_count); end
        // Reset during a mismatching valid sample: reset must win.
        reset    = 1'b1;
        in_valid = 1'b1;
        in_count = 7'd100;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL mid_locked got %b want 0", locked); end
        n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL mid_err_pulse got %b want 0", err_pulse); end
        n_tests++; if (wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL mid_wrap_pulse got %b want 0", wrap_pulse); end
        n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL mid_err_count got %0d want 0", err_count); end
        // From IDLE, sample 1 only seeds: 2,3,4 are three good steps, 5 the fourth.
        send(7'd1); send(7'd2); send(7'd3); send(7'd4);
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL mid_idle_early got %b want 0", locked); end
        send(7'd5);
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL mid_idle_lock got %b want 1", locked); end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_count = 7'd0;
        test_reset();
        test_lock();
        test_single_error();
        test_unlock_relock();
        test_wrap();
        test_acquire_cases();
        test_saturation();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
